// File: rtl/axis_exp_adc_emulator_if.sv
// AXI-Stream sample channel feeding the experiment ADC emulator.
interface axis_exp_adc_emulator_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/axis_exp_adc_emulator.sv
// SPI responder emulating the experiment ADC: cnv/busy conversion timing,
// 1/2/4-lane sample readout and 24-bit register-access command decode.
// All SPI pins are oversampled in the aclk domain.
module axis_exp_adc_emulator #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNV_CYCLES = 15
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cnv,
  output logic                    busy,
  input  logic                    spi_sck,
  input  logic                    spi_csn,
  input  logic                    spi_sdi,
  output logic [3:0]              spi_sdo,
  axis_exp_adc_emulator_if.slave  s_axis,
  output logic                    reg_mode,
  output logic [1:0]              lane_mode,
  output logic [23:0]             last_command,
  output logic                    overrun
);

  localparam int unsigned CMD_W  = 24;
  localparam int unsigned CNT_W  = (CNV_CYCLES > 1) ? $clog2(CNV_CYCLES) : 1;
  localparam int unsigned BEAT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } conv_state_t;

  // Top k bits of a word placed on the low lanes, unused lanes zero.
  function automatic logic [3:0] lanes_of(input logic [DATA_WIDTH-1:0] v,
                                          input logic [1:0] lm);
    case (lm)
      2'b01:   lanes_of = {2'b00, v[DATA_WIDTH-1 -: 2]};
      2'b10:   lanes_of = v[DATA_WIDTH-1 -: 4];
      default: lanes_of = {3'b000, v[DATA_WIDTH-1]};
    endcase
  endfunction

  // Word shifted left by the current lane width.
  function automatic logic [DATA_WIDTH-1:0] shift_lanes(input logic [DATA_WIDTH-1:0] v,
                                                        input logic [1:0] lm);
    case (lm)
      2'b01:   shift_lanes = {v[DATA_WIDTH-3:0], 2'b00};
      2'b10:   shift_lanes = {v[DATA_WIDTH-5:0], 4'b0000};
      default: shift_lanes = {v[DATA_WIDTH-2:0], 1'b0};
    endcase
  endfunction

  // Number of sck edges in a full readout at the current lane width.
  function automatic logic [BEAT_W-1:0] beats_of(input logic [1:0] lm);
    case (lm)
      2'b01:   beats_of = BEAT_W'(DATA_WIDTH / 2);
      2'b10:   beats_of = BEAT_W'(DATA_WIDTH / 4);
      default: beats_of = BEAT_W'(DATA_WIDTH);
    endcase
  endfunction

  logic [2:0] cnv_sync_q, sck_sync_q, csn_sync_q;
  logic [1:0] sdi_sync_q;

  conv_state_t           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  tready_q, tready_d;
  logic [DATA_WIDTH-1:0] pending_q, pending_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic                  data_ready_q, data_ready_d;
  logic                  defer_q, defer_d;
  logic                  frame_q, frame_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [3:0]            sdo_q, sdo_d;
  logic [CMD_W-1:0]      cmd_q, cmd_d;
  logic [CMD_W-1:0]      last_cmd_q, last_cmd_d;
  logic                  reg_mode_q, reg_mode_d;
  logic [1:0]            lane_mode_q, lane_mode_d;
  logic                  overrun_q, overrun_d;

  logic                  cnv_rise, sck_rise, csn_fall, csn_rise, sdi_s;
  logic                  conv_done;
  logic [BEAT_W-1:0]     beat_next;
  logic [DATA_WIDTH-1:0] rd_shl;

  assign cnv_rise = cnv_sync_q[1] & ~cnv_sync_q[2];
  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign csn_fall = ~csn_sync_q[1] & csn_sync_q[2];
  assign csn_rise = csn_sync_q[1] & ~csn_sync_q[2];
  assign sdi_s    = sdi_sync_q[1];

  // Pin synchronizers; csn idles high so reset does not fake a frame edge.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cnv_sync_q <= '0;
      sck_sync_q <= '0;
      csn_sync_q <= '1;
      sdi_sync_q <= '0;
    end else begin
      cnv_sync_q <= {cnv_sync_q[1:0], cnv};
      sck_sync_q <= {sck_sync_q[1:0], spi_sck};
      csn_sync_q <= {csn_sync_q[1:0], spi_csn};
      sdi_sync_q <= {sdi_sync_q[0], spi_sdi};
    end
  end

  // Next-state logic: conversion FSM, SPI readout/command capture, sample hand-over.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    tready_d     = 1'b0;
    pending_d    = pending_q;
    shift_d      = shift_q;
    rd_d         = rd_q;
    data_ready_d = data_ready_q;
    defer_d      = defer_q;
    frame_d      = frame_q;
    beat_d       = beat_q;
    sdo_d        = sdo_q;
    cmd_d        = cmd_q;
    last_cmd_d   = last_cmd_q;
    reg_mode_d   = reg_mode_q;
    lane_mode_d  = lane_mode_q;
    overrun_d    = 1'b0;
    conv_done    = 1'b0;
    beat_next    = beat_q + BEAT_W'(1);
    rd_shl       = shift_lanes(rd_q, lane_mode_q);

    case (state_q)
      ST_IDLE: begin
        if (cnv_rise && !reg_mode_q) begin
          state_d   = ST_CONV;
          busy_d    = 1'b1;
          cnt_d     = CNT_W'(CNV_CYCLES - 1);
          tready_d  = s_axis.tvalid;
          pending_d = s_axis.tvalid ? s_axis.tdata : '0;
        end
      end
      ST_CONV: begin
        if (cnt_q == '0) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          conv_done = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (csn_fall) begin
      frame_d = 1'b1;
      cmd_d   = '0;
      beat_d  = '0;
      rd_d    = shift_q;
      sdo_d   = (!reg_mode_q && data_ready_q) ? lanes_of(shift_q, lane_mode_q) : 4'h0;
    end else if (csn_rise) begin
      frame_d    = 1'b0;
      sdo_d      = 4'h0;
      last_cmd_d = cmd_q;
      if (cmd_q[23:21] == 3'b101) begin
        reg_mode_d = 1'b1;
      end else if (reg_mode_q && cmd_q[23:8] == 16'h8020) begin
        lane_mode_d = cmd_q[7:6];
      end else if (reg_mode_q && cmd_q[23:8] == 16'h8014 && cmd_q[0]) begin
        reg_mode_d = 1'b0;
      end
      if (defer_q) begin
        shift_d      = pending_q;
        data_ready_d = 1'b1;
        defer_d      = 1'b0;
      end
    end else if (sck_rise && frame_q) begin
      cmd_d = {cmd_q[CMD_W-2:0], sdi_s};
      if (!reg_mode_q && data_ready_q) begin
        beat_d = beat_next;
        if (beat_next == beats_of(lane_mode_q)) begin
          data_ready_d = 1'b0;
          sdo_d        = 4'h0;
        end else begin
          rd_d  = rd_shl;
          sdo_d = lanes_of(rd_shl, lane_mode_q);
        end
      end
    end

    // A finished sample waits for the end of an open frame before replacing shift.
    if (conv_done) begin
      overrun_d = data_ready_q | defer_q;
      if (frame_q && !csn_rise) begin
        defer_d = 1'b1;
      end else begin
        shift_d      = pending_q;
        data_ready_d = 1'b1;
        defer_d      = 1'b0;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      tready_q     <= 1'b0;
      pending_q    <= '0;
      shift_q      <= '0;
      rd_q         <= '0;
      data_ready_q <= 1'b0;
      defer_q      <= 1'b0;
      frame_q      <= 1'b0;
      beat_q       <= '0;
      sdo_q        <= 4'h0;
      cmd_q        <= '0;
      last_cmd_q   <= '0;
      reg_mode_q   <= 1'b0;
      lane_mode_q  <= 2'b00;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      tready_q     <= tready_d;
      pending_q    <= pending_d;
      shift_q      <= shift_d;
      rd_q         <= rd_d;
      data_ready_q <= data_ready_d;
      defer_q      <= defer_d;
      frame_q      <= frame_d;
      beat_q       <= beat_d;
      sdo_q        <= sdo_d;
      cmd_q        <= cmd_d;
      last_cmd_q   <= last_cmd_d;
      reg_mode_q   <= reg_mode_d;
      lane_mode_q  <= lane_mode_d;
      overrun_q    <= overrun_d;
    end
  end

  assign busy          = busy_q;
  assign spi_sdo       = sdo_q;
  assign s_axis.tready = tready_q;
  assign reg_mode      = reg_mode_q;
  assign lane_mode     = lane_mode_q;
  assign last_command  = last_cmd_q;
  assign overrun       = overrun_q;

endmodule
